// File: rtl/w_ram_pkg.sv
// Shared constants and helpers for the multi-port SHA-256 W-word RAM.
package w_ram_pkg;

  localparam int W_BW_DEF      = 31;
  localparam int W_ADDR_BW_DEF = 5;
  localparam int W_N_RD_DEF    = 4;

  // Message-schedule taps used by the round datapath: W[t-2], W[t-7], W[t-15], W[t-16].
  localparam int SCHED_OFF_2  = 2;
  localparam int SCHED_OFF_7  = 7;
  localparam int SCHED_OFF_15 = 15;
  localparam int SCHED_OFF_16 = 16;

  function automatic int w_depth(input int addr_bw);
    return 1 << (addr_bw + 1);
  endfunction

endpackage

// File: rtl/w_ram_rd_port.sv
// One registered read port: captures RAM data or the same-cycle write data, plus hit/valid flags.
module w_ram_rd_port #(
  parameter int BW = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en_i,
  input  logic [BW:0] ram_data_i,
  input  logic        ram_hit_i,
  input  logic        fwd_i,
  input  logic [BW:0] fwd_data_i,
  output logic [BW:0] data_o,
  output logic        vld_o,
  output logic        hit_o
);

  logic [BW:0] data_q, data_d;
  logic        vld_q, vld_d;
  logic        hit_q, hit_d;

  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    hit_d  = hit_q;
    if (rd_en_i) begin
      vld_d = 1'b1;
      // Write-first: a same-cycle write to this address wins over the stored word.
      if (fwd_i) begin
        data_d = fwd_data_i;
        hit_d  = 1'b1;
      end else begin
        data_d = ram_data_i;
        hit_d  = ram_hit_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      hit_q  <= hit_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign hit_o  = hit_q;

endmodule

// File: rtl/w_ram_mp.sv
// W-word RAM: one write port with auto-increment pointer and valid bitmap, N_RD registered read ports.
module w_ram_mp
  import w_ram_pkg::*;
#(
  parameter int BW       = W_BW_DEF,
  parameter int wAddr_BW = W_ADDR_BW_DEF,
  parameter int N_RD     = W_N_RD_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           we,
  input  logic                           wr_auto,
  input  logic [wAddr_BW:0]              addr_W,
  input  logic [BW:0]                    data_in,
  input  logic [N_RD-1:0]                rd_en,
  input  logic [N_RD*(wAddr_BW+1)-1:0]   addr_R,
  output logic [N_RD*(BW+1)-1:0]         data_out,
  output logic [N_RD-1:0]                rd_vld,
  output logic [N_RD-1:0]                rd_hit,
  output logic [wAddr_BW:0]              wr_ptr,
  output logic [wAddr_BW+1:0]            wr_count,
  output logic                           full
);

  localparam int AW    = wAddr_BW + 1;
  localparam int DW    = BW + 1;
  localparam int DEPTH = w_depth(wAddr_BW);
  localparam logic [wAddr_BW+1:0] DEPTH_CNT = (wAddr_BW + 2)'(DEPTH);

  logic [BW:0]         ram_q [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d, valid_base;
  logic [wAddr_BW:0]   wr_ptr_q, wr_ptr_d, ptr_base;
  logic [wAddr_BW+1:0] wr_count_q, wr_count_d, cnt_base;
  logic [wAddr_BW:0]   wa;

  // clr resets bookkeeping first; the same-cycle write is then applied on top of the cleared state.
  always_comb begin
    valid_base = clr ? '0 : valid_q;
    ptr_base   = clr ? '0 : wr_ptr_q;
    cnt_base   = clr ? '0 : wr_count_q;
    wa         = wr_auto ? ptr_base : addr_W;
    valid_d    = valid_base;
    wr_ptr_d   = ptr_base;
    wr_count_d = cnt_base;
    if (we) begin
      valid_d[wa] = 1'b1;
      if (!valid_base[wa] && (cnt_base != DEPTH_CNT)) wr_count_d = cnt_base + 1'b1;
      if (wr_auto) wr_ptr_d = ptr_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) ram_q[wa] <= data_in;
  end

  generate
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [wAddr_BW:0] rd_addr;
      logic              fwd;
      logic              hit_src;

      assign rd_addr = addr_R[gi*AW +: AW];
      assign fwd     = we && (rd_addr == wa);
      // A read in a clr cycle sees the bitmap already cleared.
      assign hit_src = valid_q[rd_addr] & ~clr;

      w_ram_rd_port #(.BW(BW)) u_rd_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en_i    (rd_en[gi]),
        .ram_data_i (ram_q[rd_addr]),
        .ram_hit_i  (hit_src),
        .fwd_i      (fwd),
        .fwd_data_i (data_in),
        .data_o     (data_out[gi*DW +: DW]),
        .vld_o      (rd_vld[gi]),
        .hit_o      (rd_hit[gi])
      );
    end
  endgenerate

  assign wr_ptr   = wr_ptr_q;
  assign wr_count = wr_count_q;
  assign full     = (wr_count_q == DEPTH_CNT);

endmodule

// File: tb/tb_w_ram_mp.sv
// Directed bench for w_ram_mp: auto/explicit writes, forwarding, clr, hit flags and async reset.
module tb_w_ram_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        we;
  logic        wr_auto;
  logic [5:0]  addr_W;
  logic [31:0] data_in;
  logic [3:0]  rd_en;
  logic [23:0] addr_R;
  logic [127:0] data_out;
  logic [3:0]  rd_vld;
  logic [3:0]  rd_hit;
  logic [5:0]  wr_ptr;
  logic [6:0]  wr_count;
  logic        full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  w_ram_mp #(.BW(31), .wAddr_BW(5), .N_RD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .we       (we),
    .wr_auto  (wr_auto),
    .addr_W   (addr_W),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .addr_R   (addr_R),
    .data_out (data_out),
    .rd_vld   (rd_vld),
    .rd_hit   (rd_hit),
    .wr_ptr   (wr_ptr),
    .wr_count (wr_count),
    .full     (full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("check %s ok value=0x%0h", tag, obs);
    end
  endtask

  function automatic logic [31:0] dout(input int k);
    return data_out[k*32 +: 32];
  endfunction

  task automatic set_addr(input logic [5:0] a0, input logic [5:0] a1,
                          input logic [5:0] a2, input logic [5:0] a3);
    addr_R = {a3, a2, a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; wr_auto = 1'b0; addr_W = '0; data_in = '0; rd_en = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_addr(0, 0, 0, 0);
    step(); step();

    // Reset state
    chk("rst_ptr",   64'(wr_ptr),   64'd0);
    chk("rst_count", 64'(wr_count), 64'd0);
    chk("rst_full",  64'(full),     64'd0);
    chk("rst_vld",   64'(rd_vld),   64'd0);
    chk("rst_hit",   64'(rd_hit),   64'd0);
    chk("rst_dout",  64'(data_out[63:0]), 64'd0);
    rst_n = 1'b1;
    step();

    // Read of never-written entry: valid but no hit
    rd_en = 4'b1111; set_addr(5, 5, 5, 5);
    step();
    chk("nowr_vld",   64'(rd_vld),   64'hF);
    chk("nowr_hit",   64'(rd_hit),   64'h0);
    chk("nowr_count", 64'(wr_count), 64'd0);
    rd_en = 4'b0000;
    step();
    chk("idle_vld", 64'(rd_vld), 64'h0);

    // Write-first forwarding on port 2 with explicit address
    we = 1'b1; wr_auto = 1'b0; addr_W = 6'd9; data_in = 32'hDEADBEEF;
    rd_en = 4'b0100; set_addr(1, 1, 9, 1);
    step();
    chk("fwd_dout2", 64'(dout(2)), 64'hDEADBEEF);
    chk("fwd_hit",   64'(rd_hit),  64'h4);
    chk("fwd_vld",   64'(rd_vld),  64'h4);
    chk("fwd_count", 64'(wr_count), 64'd1);
    chk("fwd_ptr",   64'(wr_ptr),  64'd0);

    // Explicit writes twice to 12
    rd_en = 4'b0000; addr_W = 6'd12; data_in = 32'h11111111;
    step();
    chk("exp1_count", 64'(wr_count), 64'd2);
    data_in = 32'h22222222;
    step();
    chk("exp2_count", 64'(wr_count), 64'd2);
    chk("exp2_ptr",   64'(wr_ptr),   64'd0);
    idle(); rd_en = 4'b0001; set_addr(12, 0, 0, 0);
    step();
    chk("exp_rd_dout0", 64'(dout(0)), 64'h22222222);
    chk("exp_rd_hit0",  64'(rd_hit[0]), 64'd1);

    // 64 auto writes fill the RAM
    idle();
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; wr_auto = 1'b1; data_in = 32'h1000_0000 + 32'(i);
      step();
    end
    idle();
    chk("fill_count", 64'(wr_count), 64'd64);
    chk("fill_full",  64'(full),     64'd1);
    chk("fill_ptr",   64'(wr_ptr),   64'd0);
    rd_en = 4'b1111; set_addr(0, 7, 15, 63);
    step();
    chk("fill_dout0", 64'(dout(0)), 64'h1000_0000);
    chk("fill_dout1", 64'(dout(1)), 64'h1000_0007);
    chk("fill_dout2", 64'(dout(2)), 64'h1000_000F);
    chk("fill_dout3", 64'(dout(3)), 64'h1000_003F);
    chk("fill_hit",   64'(rd_hit),  64'hF);

    // clr with same-cycle auto write and reads
    clr = 1'b1; we = 1'b1; wr_auto = 1'b1; data_in = 32'hA5A5A5A5;
    rd_en = 4'b0011; set_addr(0, 3, 0, 0);
    step();
    chk("clr_count", 64'(wr_count), 64'd1);
    chk("clr_ptr",   64'(wr_ptr),   64'd1);
    chk("clr_full",  64'(full),     64'd0);
    chk("clr_dout0", 64'(dout(0)),  64'hA5A5A5A5);
    chk("clr_dout1", 64'(dout(1)),  64'h1000_0003);
    chk("clr_hit",   64'(rd_hit[1:0]), 64'h1);
    clr = 1'b0; we = 1'b0; wr_auto = 1'b0;
    step();
    chk("post_clr_dout0", 64'(dout(0)), 64'hA5A5A5A5);
    chk("post_clr_dout1", 64'(dout(1)), 64'h1000_0003);
    chk("post_clr_hit",   64'(rd_hit[1:0]), 64'h1);

    // Async reset mid-burst
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; wr_auto = 1'b1; data_in = 32'h3000_0000 + 32'(i);
      rd_en = 4'b0001; set_addr(6'(i), 0, 0, 0);
      step();
    end
    chk("burst_ptr", 64'(wr_ptr),   64'd21);
    chk("burst_vld", 64'(rd_vld),   64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ptr",   64'(wr_ptr),   64'd0);
    chk("mid_rst_count", 64'(wr_count), 64'd0);
    chk("mid_rst_vld",   64'(rd_vld),   64'h0);
    chk("mid_rst_dout",  64'(data_out[63:0]), 64'd0);
    idle();
    step(); step();
    rst_n = 1'b1;
    we = 1'b1; wr_auto = 1'b1; data_in = 32'hCAFEF00D;
    step();
    chk("rel_ptr",   64'(wr_ptr),   64'd1);
    chk("rel_count", 64'(wr_count), 64'd1);
    idle(); rd_en = 4'b1000; set_addr(0, 0, 0, 0);
    step();
    chk("rel_dout3", 64'(dout(3)),   64'hCAFEF00D);
    chk("rel_hit3",  64'(rd_hit[3]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/w_ram_mp.md
Name: w_ram_mp

Overview:
- Parametrised successor to the SHA-256 message-schedule W-word RAM.
- Generic depth, data width and read-port count; one write port.
- Adds an auto-increment write pointer, a per-entry written/valid bitmap with clear, write-first forwarding, and registered read outputs with per-port valid.
- Sits between the message loader / schedule expander (writer) and the round datapath (reader of W[t-2], W[t-7], W[t-15], W[t-16] and similar).

Parameters:
- BW, 31: MSB index of a data word (word width BW+1).
- wAddr_BW, 5: MSB index of an address. DEPTH = 2^(wAddr_BW+1).
- N_RD, 4: number of read ports, 1..8.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of valid bitmap, write pointer and count.
- we  in  1  write enable.
- wr_auto  in  1  1 = write address from internal pointer; 0 = from addr_W.
- addr_W  in  wAddr_BW+1  explicit write address.
- data_in  in  BW+1  write data.
- rd_en  in  N_RD  per-port read request.
- addr_R  in  N_RD*(wAddr_BW+1)  packed read addresses; port k in slice k.
- data_out  out  N_RD*(BW+1)  packed registered read data.
- rd_vld  out  N_RD  port k data_out updated this cycle.
- rd_hit  out  N_RD  port k read an entry written since the last clr/reset.
- wr_ptr  out  wAddr_BW+1  next auto-write address.
- wr_count  out  wAddr_BW+2  number of valid entries, 0..DEPTH.
- full  out  1  wr_count == DEPTH.

Behaviour:
- Reset (rst_n low, async) clears:
  - wr_ptr, wr_count, full, valid bitmap;
  - data_out, rd_vld, rd_hit.
  - RAM contents are not reset.
- Effective write address WA = wr_auto ? wr_ptr : addr_W.
  - On we: ram[WA] <= data_in; valid[WA] <= 1.
  - If we && wr_auto: wr_ptr <= wr_ptr+1, modulo DEPTH; wraps DEPTH-1 -> 0.
  - wr_ptr is not changed by explicit-address writes.
- wr_count increments only when a write hits an entry whose valid bit is 0, and saturates at DEPTH.
  - Overwriting a valid entry leaves wr_count unchanged.
  - Writes when full are allowed and overwrite.
- clr:
  - Valid bitmap, wr_ptr and wr_count go to 0 first.
  - A same-cycle we is then applied: WA is computed with wr_ptr = 0 if wr_auto. Result: valid = only bit WA, count = 1, wr_ptr = 1 if auto (else 0).
  - clr does not touch data_out or RAM contents.
  - clr does not suppress a same-cycle read, but rd_hit for that read is 0 unless it is forwarded from the same-cycle write.
- Read port k, latency 1:
  - If rd_en[k]: data_out[k] <= ram[addr_R[k]]; rd_vld[k] <= 1; rd_hit[k] <= valid[addr_R[k]].
  - Otherwise data_out[k] holds its value and rd_vld[k] <= 0; rd_hit[k] holds.
- Write-first forwarding: if we and addr_R[k] == WA in the same cycle, data_out[k] <= data_in and rd_hit[k] <= 1.
- Multiple ports reading the same address is allowed; all receive identical data.
- Only one write per cycle; there is no write collision case.
- Reset asserted mid-operation aborts immediately. Outputs read zero and rd_vld = 0 until new rd_en cycles after rst_n deassert.

Decomposition:
- Shared package w_ram_pkg holds:
  - default BW / wAddr_BW / N_RD;
  - SHA-256 schedule offsets (2, 7, 15, 16) as constants;
  - a function computing DEPTH from wAddr_BW.
- One natural sub-module: w_ram_rd_port.
  - Holds a registered read/forward/hit for a single port.
  - Instantiated N_RD times via generate.
- Top level holds the storage array, pointer, bitmap and counter.

Test Plan:
- Reset, then 64 auto writes of data_in = 0x1000_0000+i, then read i=0,7,15,63 on ports 0..3 -> next cycle data_out = 0x1000_0000, 0x1000_0007, 0x1000_000F, 0x1000_003F; rd_hit = 4'b1111; wr_count = 64; full = 1; wr_ptr = 0.
- After reset, rd_en all on address 5 with no prior write -> rd_vld = 1111, rd_hit = 0000; wr_count = 0.
- Same-cycle write addr_W = 9, data 0xDEADBEEF, and port 2 reading 9 -> next cycle data_out[2] = 0xDEADBEEF, rd_hit[2] = 1; other ports unaffected.
- Full RAM, clr with auto write 0xA5A5A5A5 in the same cycle -> wr_count = 1, wr_ptr = 1; a read of address 0 returns 0xA5A5A5A5 with hit = 1; a read of address 3 returns old data with hit = 0.
- Explicit write twice to address 12 -> wr_count increments once; wr_ptr unchanged; second value read back.
- Assert rst_n low mid-burst (after 20 auto writes, reads active) -> immediately wr_ptr = 0, wr_count = 0, rd_vld = 0, data_out = 0; after release, auto write lands at address 0.
